// File: rtl/sram_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter: controller states and
// default geometry of the shared SRAM macro.
package sram_arb_pkg;

    localparam int BITS_DEF       = 16;
    localparam int WORD_DEPTH_DEF = 256;
    localparam int ADD_WIDTH_DEF  = 8;

    // INIT clears the macro after reset; RUN serves the two requesters.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is purely combinational from the
// requests; the priority flop only moves when both ports compete.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_prio;  // 0: port 0 wins a contest, 1: port 1 wins

    // Grant the lone requester, or the priority holder when both request.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Hand priority to the losing port after every contested grant.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_prio <= 1'b0;
        end else if (&req) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port SRAM macro between two requesters. After reset the
// macro is cleared word by word (INIT); afterwards one request per cycle is
// issued to the macro in the acceptance cycle, and read data returns one cycle
// later on the response valid of the originating port.
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int BITS       = BITS_DEF,
    parameter int WORD_DEPTH = WORD_DEPTH_DEF,
    parameter int ADD_WIDTH  = ADD_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTB,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [ADD_WIDTH-1:0] req0_addr,
    input  logic [BITS-1:0]      req0_wdata,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [ADD_WIDTH-1:0] req1_addr,
    input  logic [BITS-1:0]      req1_wdata,

    output logic                 resp0_valid,
    output logic                 resp1_valid,
    output logic [BITS-1:0]      resp_rdata,

    output logic                 init_done,

    output logic                 sram_ceb,
    output logic                 sram_web,
    output logic [ADD_WIDTH-1:0] sram_a,
    output logic [BITS-1:0]      sram_d,
    input  logic [BITS-1:0]      sram_q
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [ADD_WIDTH-1:0]   r_init_cnt;
    logic                   r_init_done;
    logic [1:0]             r_resp_pend;  // read issued last cycle, per port
    logic [1:0]             w_req;
    logic [1:0]             w_gnt;
    logic                   w_run;
    logic                   w_init_last;

    assign w_run       = (r_state == RUN);
    assign w_init_last = (r_init_cnt == ADD_WIDTH'(WORD_DEPTH - 1));

    // Requests are invisible to the arbiter until the clear has finished, so
    // neither ready nor the priority pointer can move during INIT or reset.
    assign w_req = {req1_valid, req0_valid} & {2{w_run}};

    rr_arb2 u_rr_arb2 (
        .CLK  (CLK),
        .RSTB (RSTB),
        .req  (w_req),
        .gnt  (w_gnt)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    // Next state and macro strobes: clear writes in INIT, the granted
    // request in RUN, idle otherwise.
    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        sram_ceb    = 1'b1;
        sram_web    = 1'b1;
        sram_a      = '0;
        sram_d      = '0;
        // Strobes are gated by RSTB itself so the macro sees a static idle
        // bus for the whole reset pulse, not just after the first edge.
        if (RSTB) begin
            unique case (r_state)
                INIT: begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = r_init_cnt;
                    if (w_init_last) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_gnt[0]) begin
                        sram_ceb = 1'b0;
                        sram_web = ~req0_we;
                        sram_a   = req0_addr;
                        sram_d   = req0_wdata;
                    end else if (w_gnt[1]) begin
                        sram_ceb = 1'b0;
                        sram_web = ~req1_we;
                        sram_a   = req1_addr;
                        sram_d   = req1_wdata;
                    end
                end
                default: w_state_nxt = INIT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear address counter and the sticky completion flag.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            r_init_done <= (w_state_nxt == RUN);
        end
    end

    // Remember which port had a read issued so its data can be tagged on
    // the following cycle; writes never produce a response.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_resp_pend <= 2'b00;
        end else begin
            r_resp_pend <= w_gnt & ~{req1_we, req0_we};
        end
    end

    assign init_done   = r_init_done;
    assign resp0_valid = r_resp_pend[0];
    assign resp1_valid = r_resp_pend[1];
    assign resp_rdata  = (|r_resp_pend) ? sram_q : '0;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Self-checking bench for sram_1rw_arbiter: a behavioural SRAM macro plus a
// reference model (memory array, priority bit, pending-response record)
// predicting every output each cycle.
module tb_sram_1rw_arbiter;

    localparam int BITS  = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic            CLK = 1'b0;
    logic            RSTB;
    logic [1:0]      v, we;
    logic [AW-1:0]   ad [2];
    logic [BITS-1:0] wd [2];
    logic            req0_ready, req1_ready;
    logic            resp0_valid, resp1_valid;
    logic [BITS-1:0] resp_rdata;
    logic            init_done;
    logic            sram_ceb, sram_web;
    logic [AW-1:0]   sram_a;
    logic [BITS-1:0] sram_d, sram_q;

    always #5 CLK = ~CLK;

    sram_1rw_arbiter #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADD_WIDTH(AW)) dut (
        .CLK(CLK), .RSTB(RSTB),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(we[0]),
        .req0_addr(ad[0]), .req0_wdata(wd[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(we[1]),
        .req1_addr(ad[1]), .req1_wdata(wd[1]),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_rdata(resp_rdata), .init_done(init_done),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Single-port macro: write or read on a low strobe, read data for one
    // cycle after the strobe, random garbage at all other times.
    logic [BITS-1:0] sram_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = BITS'($urandom);
    always @(posedge CLK) begin
        if (!sram_ceb && !sram_web) sram_mem[sram_a] <= sram_d;
        if (!sram_ceb && sram_web) sram_q <= sram_mem[sram_a];
        else                       sram_q <= BITS'($urandom);
    end

    // Reference model state.
    bit              m_run;
    int              m_cnt;
    bit              m_prio;
    logic [BITS-1:0] m_mem [DEPTH];
    int              m_pend;       // port owed a response next cycle, -1 none
    logic [BITS-1:0] m_pend_data;
    int              m_gnt;        // port granted in the last stepped cycle

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]      obs_rdy;
    logic [BITS-1:0] obs_rdata;
    logic            obs_done;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 0;
        m_prio = 1'b0;
        m_pend = -1;
        m_gnt  = -1;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, advance
    // the model for the coming edge, then return just after that edge.
    task automatic step(input bit rst_before_edge = 1'b0);
        logic [1:0]      e_rdy;
        logic            e_ceb, e_web;
        logic [AW-1:0]   e_a;
        logic [BITS-1:0] e_d, e_rd;
        int              g;
        @(negedge CLK);
        obs_rdy   = {req1_ready, req0_ready};
        obs_rdata = resp_rdata;
        obs_done  = init_done;
        if (!RSTB) begin
            check("rst_ceb", sram_ceb, 1'b1);
            check("rst_web", sram_web, 1'b1);
            check("rst_ready", obs_rdy, 2'b00);
            check("rst_resp", {resp1_valid, resp0_valid}, 2'b00);
            check("rst_init_done", init_done, 1'b0);
            m_gnt = -1;
        end else begin
            g = -1;
            if (!m_run) begin
                e_rdy = 2'b00; e_ceb = 1'b0; e_web = 1'b0;
                e_a = AW'(m_cnt); e_d = '0;
            end else begin
                if (v[0] && v[1]) g = m_prio ? 1 : 0;
                else if (v[0])    g = 0;
                else if (v[1])    g = 1;
                e_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
                if (g >= 0) begin
                    e_ceb = 1'b0; e_web = ~we[g]; e_a = ad[g]; e_d = wd[g];
                end else begin
                    e_ceb = 1'b1; e_web = 1'b1; e_a = '0; e_d = '0;
                end
            end
            e_rd = (m_pend >= 0) ? m_pend_data : '0;
            check("ready", obs_rdy, e_rdy);
            check("sram_ceb", sram_ceb, e_ceb);
            check("sram_web", sram_web, e_web);
            check("sram_a", sram_a, e_a);
            check("sram_d", sram_d, e_d);
            check("resp0_valid", resp0_valid, m_pend == 0);
            check("resp1_valid", resp1_valid, m_pend == 1);
            check("resp_rdata", obs_rdata, e_rd);
            check("init_done", init_done, m_run);
            m_pend = -1;
            if (!m_run) begin
                m_mem[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) m_run = 1'b1;
                else                    m_cnt++;
            end else if (g >= 0) begin
                if (v[0] && v[1]) m_prio = ~m_prio;
                if (we[g]) m_mem[ad[g]] = wd[g];
                else begin
                    m_pend      = g;
                    m_pend_data = m_mem[ad[g]];
                end
            end
            m_gnt = g;
        end
        if (rst_before_edge) begin
            RSTB = 1'b0;
            model_reset();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [BITS-1:0] d);
        v[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d;
    endtask

    initial begin
        int cyc;
        v = 2'b00; we = 2'b00;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        RSTB = 1'b0;
        model_reset();
        repeat (2) step();
        RSTB = 1'b1;

        // Read of 0xFF pending through the whole clear: 256 clear cycles,
        // accepted in the first RUN cycle, returns the cleared value.
        issue(0, 1'b0, 8'hFF, '0);
        cyc = 0;
        do begin step(); cyc++; end while (m_gnt != 0 && cyc < 400);
        check("init_accept_cycle", cyc, 257);
        check("init_accept_rdy", obs_rdy, 2'b01);
        v = 2'b00;
        step();
        check("init_read_zero", obs_rdata, 16'h0000);

        // Write then immediate read of the same address.
        issue(0, 1'b1, 8'h12, 16'hBEEF);
        step();
        issue(0, 1'b0, 8'h12, '0);
        step();
        v = 2'b00;
        step();
        check("wr_rd_beef", obs_rdata, 16'hBEEF);

        // Both ports reading continuously: strict alternation starting at 0.
        issue(0, 1'b0, AW'($urandom), '0);
        issue(1, 1'b0, AW'($urandom), '0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("alt_grant", obs_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (m_gnt >= 0) ad[m_gnt] = AW'($urandom);
        end
        v = 2'b00;

        // Port 1 alone back-to-back, then a contest still goes to port 0.
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b0, AW'($urandom), '0);
            step();
            check("solo_p1", obs_rdy, 2'b10);
        end
        issue(0, 1'b0, AW'($urandom), '0);
        issue(1, 1'b0, AW'($urandom), '0);
        step();
        check("contest_p0_first", obs_rdy, 2'b01);
        v = 2'b00;
        step();

        // Random traffic on a small address window to hit read-after-write.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!v[p] && $urandom_range(0, 2) != 0)
                    issue(p, 1'($urandom), AW'($urandom_range(0, 7)), BITS'($urandom));
            end
            step();
            if (m_gnt >= 0) v[m_gnt] = 1'b0;
        end
        v = 2'b00;
        step();

        // Reset right after a port 1 read is accepted: no response, clear
        // restarts at address 0 and takes the full 256 cycles again.
        issue(1, 1'b0, 8'h03, '0);
        step(1'b1);
        check("rst_accept", obs_rdy, 2'b10);
        v = 2'b00;
        repeat (2) step();
        RSTB = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (!obs_done && cyc < 400);
        check("reinit_len", cyc, 257);
        for (int i = 0; i < 4; i++) begin
            issue(i % 2, 1'b0, AW'($urandom), '0);
            step();
            v = 2'b00;
            step();
            check("reinit_read_zero", obs_rdata, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
